// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if
//   Unified memory port bus between the arbiter and the memory.
//   master modport : arbiter side (drives request, write enable, address, data, strobes)
//   slave  modport : memory side (drives ready and read data)
//   Signals:
//     mem_req   - request, held until mem_ready
//     mem_we    - write enable
//     mem_addr  - word address, bits [1:0] are always 0
//     mem_wdata - lane-replicated write data
//     mem_wstrb - byte strobes, 0 on reads
//     mem_ready - completion; mem_rdata valid in the same cycle
//     mem_rdata - read data
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares the single memory port of the multi-cycle core between the
//   instruction-fetch requester and the load/store requester. One transaction
//   at a time, fixed priority load/store over fetch. Loads are formatted
//   (byte/half select, sign/zero extend) into a held register; stores get
//   byte strobes and lane-replicated write data.
//
//   Optional build macro MEMARB_TIMEOUT_EN: adds a WAIT watchdog that ends a
//   transaction with err after TIMEOUT_CYCLES cycles without mem_ready.
//
//   Ports:
//     clk, rst        - clock, asynchronous active-high reset
//     if_req_i        - fetch request (level, held until if_done_o)
//     if_addr_i       - fetch address
//     if_done_o       - one-cycle fetch completion pulse
//     if_rdata_o      - fetched instruction, held
//     ls_req_i        - load/store request (level, held until ls_done_o)
//     ls_we_i         - 1 = store, 0 = load
//     ls_addr_i       - byte address
//     ls_wdata_i      - right-aligned store data
//     ls_funct3_i     - RV32I width/sign code
//     ls_done_o       - one-cycle load/store completion pulse
//     ls_rdata_o      - formatted load data, held
//     err_o           - pulses with done on illegal access or timeout
//     busy_o          - arbiter not idle
//     mem             - memory bus (mem_access_arbiter_if.master)
module mem_access_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [2:0]        ls_funct3_i,
    output logic              ls_done_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              err_o,
    output logic              busy_o,
    mem_access_arbiter_if.master mem
);

    // Strobe and formatting logic assume four byte lanes.
    if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_access_arbiter: DATA_W must be 32 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] F3_WORD = 3'b010;

    logic [1:0]        state_q,    state_d;
    logic              own_ls_q,   own_ls_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [2:0]        f3_q,       f3_d;
    logic              err_q,      err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic              in_wait;
    logic              timeout;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_f3;
    logic              sel_we;
    logic              sel_illegal;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_fmt;
    logic [3:0]        store_strb;
    logic [DATA_W-1:0] store_data;

    // Fetches are checked only for word alignment; loads/stores by width code.
    function automatic logic access_illegal(input logic       is_ls,
                                            input logic       we,
                                            input logic [1:0] a,
                                            input logic [2:0] f3);
        logic bad;
        if (!is_ls) begin
            bad = (a != 2'b00);
        end else begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b100:  bad = we;
                3'b001:  bad = a[0];
                3'b101:  bad = we | a[0];
                3'b010:  bad = (a != 2'b00);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    assign sel_addr    = ls_req_i ? ls_addr_i : if_addr_i;
    assign sel_f3      = ls_req_i ? ls_funct3_i : F3_WORD;
    assign sel_we      = ls_req_i & ls_we_i;
    assign sel_illegal = access_illegal(ls_req_i, sel_we, sel_addr[1:0], sel_f3);

    assign in_wait = (state_q == ST_WAIT);

`ifdef MEMARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Counter is cleared outside WAIT, so it reads 0 on the first WAIT cycle;
    // the last permitted WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_wait && !mem.mem_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Load formatting from the latched byte address.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = mem.mem_rdata[7:0];
            2'd1:    rd_byte = mem.mem_rdata[15:8];
            2'd2:    rd_byte = mem.mem_rdata[23:16];
            default: rd_byte = mem.mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_fmt = {24'd0, rd_byte};
            3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_fmt = {16'd0, rd_half};
            default: load_fmt = mem.mem_rdata;
        endcase
    end

    // Store strobes and lane replication.
    always_comb begin
        case (f3_q[1:0])
            2'd0: begin
                store_strb = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                store_strb = addr_q[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        own_ls_d   = own_ls_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ls_req_i || if_req_i) begin
                    own_ls_d = ls_req_i;
                    addr_d   = sel_addr;
                    we_d     = sel_we;
                    wdata_d  = ls_req_i ? ls_wdata_i : '0;
                    f3_d     = sel_f3;
                    err_d    = sel_illegal;
                    state_d  = sel_illegal ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // mem_ready takes precedence over a coincident timeout.
                if (mem.mem_ready) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (own_ls_q) begin
                            ls_rdata_d = load_fmt;
                        end else begin
                            if_rdata_d = mem.mem_rdata;
                        end
                    end
                end else if (timeout) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            own_ls_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            f3_q       <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            own_ls_q   <= own_ls_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // mem_req decodes the state register so it drops the instant rst rises.
    assign mem.mem_req   = in_wait;
    assign mem.mem_we    = in_wait & we_q;
    assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata = store_data;
    assign mem.mem_wstrb = (in_wait && we_q) ? store_strb : 4'b0000;

    assign if_done_o  = (state_q == ST_DONE) & ~own_ls_q;
    assign ls_done_o  = (state_q == ST_DONE) &  own_ls_q;
    assign err_o      = (state_q == ST_DONE) &  err_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign if_rdata_o = if_rdata_q;
    assign ls_rdata_o = ls_rdata_q;

endmodule
